// File: rtl/deserializer.sv
// Serial-to-parallel receiver: framed words in (start, data LSB first, optional parity, stop)
// with a valid/ready output holding register. Define PARITY_EN to enable the even-parity bit.
module deserializer #(
    parameter int DATA_WIDTH = 8
) (
    input  logic                  clock_in,
    input  logic                  reset_n,
    input  logic                  Data_in,
    input  logic                  Bit_en,
    input  logic                  Data_ready,
    output logic [DATA_WIDTH-1:0] Data_out,
    output logic                  Data_valid,
    output logic                  Frame_error,
    output logic                  Parity_error,
    output logic                  Overrun
);

    localparam int CNT_W = $clog2(DATA_WIDTH);
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DATA   = 2'd1,
`ifdef PARITY_EN
        ST_PARITY = 2'd2,
`endif
        ST_STOP   = 2'd3
    } state_t;

    state_t                  state_q;
    logic [CNT_W-1:0]        bit_cnt_q;
    logic [DATA_WIDTH-1:0]   shift_q;
    logic [DATA_WIDTH-1:0]   data_out_q;
    logic                    valid_q;
    logic                    frame_err_q;
    logic                    overrun_q;
    logic                    complete_s;
    logic                    accept_s;

`ifdef PARITY_EN
    logic                    parity_bit_q;
    logic                    parity_err_q;

    // Even parity: the stored parity bit must make the total number of ones even.
    function automatic logic parity_mismatch(input logic [DATA_WIDTH-1:0] data,
                                             input logic par_bit);
        return par_bit ^ (^data);
    endfunction
`endif

    assign complete_s = Bit_en && (state_q == ST_STOP);
    assign accept_s   = valid_q && Data_ready;

    // Frame FSM, shift register and output holding register.
    always_ff @(posedge clock_in or negedge reset_n) begin
        if (!reset_n) begin
            state_q      <= ST_IDLE;
            bit_cnt_q    <= {CNT_W{1'b0}};
            shift_q      <= {DATA_WIDTH{1'b0}};
            data_out_q   <= {DATA_WIDTH{1'b0}};
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            overrun_q    <= 1'b0;
`ifdef PARITY_EN
            parity_bit_q <= 1'b0;
            parity_err_q <= 1'b0;
`endif
        end else begin
            if (Bit_en) begin
                case (state_q)
                    ST_IDLE: begin
                        if (!Data_in) begin
                            state_q   <= ST_DATA;
                            bit_cnt_q <= {CNT_W{1'b0}};
                        end
                    end
                    ST_DATA: begin
                        shift_q   <= {Data_in, shift_q[DATA_WIDTH-1:1]};
                        bit_cnt_q <= bit_cnt_q + CNT_W'(1);
                        if (bit_cnt_q == LAST_BIT) begin
`ifdef PARITY_EN
                            state_q <= ST_PARITY;
`else
                            state_q <= ST_STOP;
`endif
                        end
                    end
`ifdef PARITY_EN
                    ST_PARITY: begin
                        parity_bit_q <= Data_in;
                        state_q      <= ST_STOP;
                    end
`endif
                    ST_STOP: state_q <= ST_IDLE;
                    default: state_q <= ST_IDLE;
                endcase
            end

            // A completing frame takes priority over a plain accept; a full, unaccepted register drops it.
            if (complete_s) begin
                if (!valid_q || Data_ready) begin
                    data_out_q   <= shift_q;
                    frame_err_q  <= ~Data_in;
                    valid_q      <= 1'b1;
`ifdef PARITY_EN
                    parity_err_q <= parity_mismatch(shift_q, parity_bit_q);
`endif
                end else begin
                    overrun_q <= 1'b1;
                end
            end else if (accept_s) begin
                valid_q <= 1'b0;
            end
        end
    end

    assign Data_out    = data_out_q;
    assign Data_valid  = valid_q;
    assign Frame_error = frame_err_q;
    assign Overrun     = overrun_q;
`ifdef PARITY_EN
    assign Parity_error = parity_err_q;
`else
    assign Parity_error = 1'b0;
`endif

endmodule

// File: tb/tb_deserializer.sv
// Randomized self-checking bench for deserializer; a frame-level model predicts the output register.
module tb_deserializer;

    localparam int DW = 8;

    logic          clock_in = 1'b0;
    logic          reset_n;
    logic          Data_in;
    logic          Bit_en;
    logic          Data_ready;
    logic [DW-1:0] Data_out;
    logic          Data_valid;
    logic          Frame_error;
    logic          Parity_error;
    logic          Overrun;

    int n_vec = 0;
    int n_err = 0;

    logic [DW-1:0] m_data;
    logic          m_valid, m_fe, m_pe, m_ovr;

    deserializer #(.DATA_WIDTH(DW)) dut (
        .clock_in     (clock_in),
        .reset_n      (reset_n),
        .Data_in      (Data_in),
        .Bit_en       (Bit_en),
        .Data_ready   (Data_ready),
        .Data_out     (Data_out),
        .Data_valid   (Data_valid),
        .Frame_error  (Frame_error),
        .Parity_error (Parity_error),
        .Overrun      (Overrun)
    );

    always #5 clock_in = ~clock_in;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_vec++;
        if (obs !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic check_all(input string ctx);
        check_eq({ctx, ".data"},  32'(Data_out),     32'(m_data));
        check_eq({ctx, ".valid"}, 32'(Data_valid),   32'(m_valid));
        check_eq({ctx, ".ferr"},  32'(Frame_error),  32'(m_fe));
        check_eq({ctx, ".perr"},  32'(Parity_error), 32'(m_pe));
        check_eq({ctx, ".ovr"},   32'(Overrun),      32'(m_ovr));
    endtask

    task automatic model_reset();
        m_data = '0; m_valid = 1'b0; m_fe = 1'b0; m_pe = 1'b0; m_ovr = 1'b0;
    endtask

    // One clock: drive at negedge, apply the output-register rules at posedge, compare at next negedge.
    task automatic cycle(input string ctx, input logic din, input logic ben, input logic rdy,
                         input logic stop_here, input logic [DW-1:0] w,
                         input logic fe, input logic pe);
        Data_in = din; Bit_en = ben; Data_ready = rdy;
        @(posedge clock_in);
        if (ben && stop_here) begin
            if (!m_valid || rdy) begin
                m_data = w; m_fe = fe; m_pe = pe; m_valid = 1'b1;
            end else begin
                m_ovr = 1'b1;
            end
        end else if (m_valid && rdy) begin
            m_valid = 1'b0;
        end
        @(negedge clock_in);
        check_all(ctx);
    endtask

    function automatic logic pick_rdy(input int mode, input logic at_stop);
        case (mode)
            0:       return 1'b0;
            1:       return 1'b1;
            2:       return 1'($urandom_range(1));
            3:       return at_stop;
            default: return 1'b1;
        endcase
    endfunction

    // Sends up to max_bits line bits of a frame, with random Bit_en=0 gaps of gap_pct percent.
    task automatic send_frame(input string ctx, input logic [DW-1:0] w, input logic stop_bit,
                              input logic par_bit, input int gap_pct, input int rdy_mode,
                              input int max_bits = 100);
        logic bits[$];
        logic pe;
        bits.push_back(1'b0);
        for (int i = 0; i < DW; i++) bits.push_back(w[i]);
`ifdef PARITY_EN
        bits.push_back(par_bit);
        pe = par_bit ^ (^w);
`else
        pe = 1'b0;
`endif
        bits.push_back(stop_bit);
        for (int k = 0; k < bits.size() && k < max_bits; k++) begin
            logic last;
            last = (k == bits.size() - 1);
            while (int'($urandom_range(99)) < gap_pct)
                cycle(ctx, 1'($urandom_range(1)), 1'b0, pick_rdy(rdy_mode, 1'b0), 1'b0, w, 1'b0, 1'b0);
            cycle(ctx, bits[k], 1'b1, pick_rdy(rdy_mode, last), last, w, ~stop_bit, pe);
        end
    endtask

    task automatic idle(input string ctx, input int n, input int rdy_mode);
        for (int i = 0; i < n; i++)
            cycle(ctx, 1'b1, 1'($urandom_range(1)), pick_rdy(rdy_mode, 1'b0), 1'b0, '0, 1'b0, 1'b0);
    endtask

    task automatic do_reset(input string ctx);
        reset_n = 1'b0;
        model_reset();
        #2;
        check_all(ctx);
        @(negedge clock_in);
        reset_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        Data_in = 1'b1; Bit_en = 1'b0; Data_ready = 1'b0; reset_n = 1'b0;
        model_reset();
        #2;
        check_all("reset");
        @(negedge clock_in);
        reset_n = 1'b1;

        send_frame("b5", 8'hB5, 1'b1, 1'b1, 0, 1);
        idle("b5_idle", 2, 1);

        send_frame("3c_ferr", 8'h3C, 1'b0, 1'b0, 0, 1);
        send_frame("a5", 8'hA5, 1'b1, 1'b0, 0, 1);
        idle("a5_idle", 1, 1);

        send_frame("ovr_11", 8'h11, 1'b1, 1'b0, 0, 0);
        send_frame("ovr_22", 8'h22, 1'b1, 1'b0, 0, 0);
        cycle("ovr_accept", 1'b1, 1'b1, 1'b1, 1'b0, '0, 1'b0, 1'b0);
        idle("ovr_idle", 1, 0);
        do_reset("ovr_rst");

        send_frame("late_11", 8'h11, 1'b1, 1'b0, 0, 3);
        send_frame("late_22", 8'h22, 1'b1, 1'b0, 0, 3);
        idle("late_idle", 2, 1);

        send_frame("par_1", 8'hB5, 1'b1, 1'b1, 0, 1);
        send_frame("par_0", 8'hB5, 1'b1, 1'b0, 0, 1);
        idle("par_idle", 1, 1);

        send_frame("gap_5a", 8'h5A, 1'b1, 1'b0, 50, 1);
        idle("gap_idle", 1, 1);
        send_frame("abort_5a", 8'h5A, 1'b1, 1'b0, 0, 1, 5);
        do_reset("mid_rst");
        idle("post_rst", 1, 1);
        send_frame("c3", 8'hC3, 1'b1, 1'b0, 0, 1);
        idle("c3_idle", 1, 1);

        for (int f = 0; f < 150; f++) begin
            send_frame("rand", DW'($urandom), ($urandom_range(7) != 0), 1'($urandom_range(1)),
                       $urandom_range(40), 2);
            idle("rand_idle", $urandom_range(2), 2);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
